// File: rtl/ex_muldiv_unit.sv
// EX-stage multiply/divide unit with HI/LO ownership.
// Iterative radix-2 engine beside the single-cycle ALU.
module ex_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             stall,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH:0]   acc_q;
  logic [WIDTH-1:0] q_q;
  logic             is_div_q;
  logic             neg_q;
  logic             negr_q;
  logic             divz_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             done_q;

  logic is_r;
  logic dec_mult, dec_multu, dec_div, dec_divu;
  logic dec_mfhi, dec_mflo, dec_mthi, dec_mtlo;
  logic dec_md, dec_mv, dec_sgn, dec_isdiv;
  logic idle, accept;

  assign is_r      = issue && (alu_op == 2'b10);
  assign dec_mult  = is_r && (funct == 6'b011000);
  assign dec_multu = is_r && (funct == 6'b011001);
  assign dec_div   = is_r && (funct == 6'b011010);
  assign dec_divu  = is_r && (funct == 6'b011011);
  assign dec_mfhi  = is_r && (funct == 6'b010000);
  assign dec_mflo  = is_r && (funct == 6'b010010);
  assign dec_mthi  = is_r && (funct == 6'b010001);
  assign dec_mtlo  = is_r && (funct == 6'b010011);

  assign dec_md    = dec_mult | dec_multu | dec_div | dec_divu;
  assign dec_mv    = dec_mfhi | dec_mflo | dec_mthi | dec_mtlo;
  assign dec_sgn   = dec_mult | dec_div;
  assign dec_isdiv = dec_div | dec_divu;

  assign idle   = (state_q == IDLE);
  assign accept = idle && dec_md;

  assign stall  = (dec_md | dec_mv) && !idle;
  assign busy   = !idle;
  assign done   = done_q;
  assign hi     = hi_q;
  assign lo     = lo_q;

  always_comb begin
    result = '0;
    if (idle && dec_mfhi) result = hi_q;
    if (idle && dec_mflo) result = lo_q;
  end

  // Operand magnitudes and sign flags captured at accept.
  logic             sa, sb;
  logic [WIDTH-1:0] rs_mag, rt_mag;

  assign sa     = dec_sgn && rs_val[WIDTH-1];
  assign sb     = dec_sgn && rt_val[WIDTH-1];
  assign rs_mag = sa ? (~rs_val + 1'b1) : rs_val;
  assign rt_mag = sb ? (~rt_val + 1'b1) : rt_val;

  logic [WIDTH:0]   acc_d;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH:0]   shl;
  logic [WIDTH+1:0] diff;
  logic [WIDTH:0]   sum;

  always_comb begin
    acc_d = acc_q;
    q_d   = q_q;
    shl   = '0;
    diff  = '0;
    sum   = '0;
    if (is_div_q) begin
      shl  = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
      diff = {1'b0, shl} - {2'b00, b_q};
      if (!diff[WIDTH+1]) begin
        acc_d = diff[WIDTH:0];
        q_d   = {q_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = shl;
        q_d   = {q_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      sum   = q_q[0] ? (acc_q + {1'b0, a_q}) : acc_q;
      acc_d = {1'b0, sum[WIDTH:1]};
      q_d   = {sum[0], q_q[WIDTH-1:1]};
    end
  end

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  always_comb begin
    prod   = {acc_q[WIDTH-1:0], q_q};
    fix_hi = '0;
    fix_lo = '0;
    if (!is_div_q) begin
      if (neg_q) prod = ~prod + 1'b1;
      fix_hi = prod[2*WIDTH-1:WIDTH];
      fix_lo = prod[WIDTH-1:0];
    end else if (divz_q) begin
      fix_hi = a_q;
      fix_lo = '1;
    end else begin
      fix_lo = neg_q ? (~q_q + 1'b1) : q_q;
      fix_hi = negr_q ? (~acc_q[WIDTH-1:0] + 1'b1)
                      : acc_q[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      q_q      <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      negr_q   <= 1'b0;
      divz_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (dec_mthi) hi_q <= rs_val;
          if (dec_mtlo) lo_q <= rs_val;
          if (accept) begin
            state_q  <= CALC;
            cnt_q    <= CW'(WIDTH);
            acc_q    <= '0;
            is_div_q <= dec_isdiv;
            neg_q    <= sa ^ sb;
            negr_q   <= sa;
            divz_q   <= dec_isdiv && (rt_val == '0);
            b_q      <= rt_mag;
            a_q      <= dec_isdiv ? rs_val : rs_mag;
            q_q      <= dec_isdiv ? rs_mag : rt_mag;
          end
        end
        CALC: begin
          acc_q <= acc_d;
          q_q   <= q_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) state_q <= FIX;
        end
        FIX: begin
          hi_q    <= fix_hi;
          lo_q    <= fix_lo;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit: vector table, random ops,
// and hand-written stall/move/reset sequences.
module tb_ex_muldiv_unit;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue;
  logic [1:0]  alu_op;
  logic [5:0]  funct;
  logic [31:0] rs_val, rt_val;
  logic        stall, busy, done;
  logic [31:0] result, hi, lo;

  always #5 clk = ~clk;

  ex_muldiv_unit #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .issue  (issue),
    .alu_op (alu_op),
    .funct  (funct),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .stall  (stall),
    .result (result),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [5:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eh;
    logic [31:0] el;
    string       nm;
  } vec_t;

  typedef struct packed {
    logic [31:0] h;
    logic [31:0] l;
  } exp_t;

  exp_t sbq[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [5:0] f,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, q, m;
    logic [63:0] r;
    sa = $signed(a);
    sb = $signed(b);
    r  = '0;
    case (f)
      F_MULT:  r = sa * sb;
      F_MULTU: r = {32'd0, a} * {32'd0, b};
      F_DIV: begin
        if (b == 0) r = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          m = sa % sb;
          r = {m[31:0], q[31:0]};
        end
      end
      F_DIVU: begin
        if (b == 0) r = {a, 32'hFFFF_FFFF};
        else r = {a % b, a / b};
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic run_md(input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh,
                        input logic [31:0] el, input string nm);
    int   n;
    bit   seen;
    exp_t e;
    @(negedge clk);
    issue  = 1'b1;
    alu_op = 2'b10;
    funct  = f;
    rs_val = a;
    rt_val = b;
    sbq.push_back({eh, el});
    @(posedge clk);
    #1;
    issue = 1'b0;
    funct = 6'd0;
    n     = 0;
    seen  = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (busy) n++;
      if (done) seen = 1'b1;
    end
    e = sbq.pop_front();
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: no done pulse", nm);
    end else begin
      chk({nm, " hi"}, hi, e.h);
      chk({nm, " lo"}, lo, e.l);
      chk({nm, " busy cycles"}, 32'(n), 32'd33);
      @(negedge clk);
      chk({nm, " done width"}, {31'd0, done}, 32'd0);
    end
  endtask

  vec_t        vt[10];
  logic [63:0] m;
  logic [5:0]  fr;
  logic [31:0] ra, rb;
  logic [31:0] prev_lo;
  int          n, dcnt;

  initial begin
    vt[0] = '{F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
              32'hFFFF_FFFE, 32'h0000_0001, "multu max"};
    vt[1] = '{F_MULT, 32'hFFFF_FFFA, 32'd7,
              32'hFFFF_FFFF, 32'hFFFF_FFD6, "mult -6*7"};
    vt[2] = '{F_DIV, 32'hFFFF_FFF9, 32'd2,
              32'hFFFF_FFFF, 32'hFFFF_FFFD, "div -7/2"};
    vt[3] = '{F_DIVU, 32'd100, 32'd7,
              32'd2, 32'd14, "divu 100/7"};
    vt[4] = '{F_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
              32'd0, 32'h8000_0000, "div ovf"};
    vt[5] = '{F_DIVU, 32'd5, 32'd0,
              32'd5, 32'hFFFF_FFFF, "divu 5/0"};
    vt[6] = '{F_DIV, 32'hFFFF_FFF7, 32'd0,
              32'hFFFF_FFF7, 32'hFFFF_FFFF, "div -9/0"};
    vt[7] = '{F_MULT, 32'h8000_0000, 32'h8000_0000,
              32'h4000_0000, 32'd0, "mult min*min"};
    vt[8] = '{F_DIV, 32'd7, 32'hFFFF_FFFE,
              32'd1, 32'hFFFF_FFFD, "div 7/-2"};
    vt[9] = '{F_MULTU, 32'h0001_0000, 32'h0001_0000,
              32'd1, 32'd0, "multu 2^32"};

    rst_n  = 1'b0;
    issue  = 1'b0;
    alu_op = 2'b00;
    funct  = 6'd0;
    rs_val = '0;
    rt_val = '0;
    #3;
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset stall", {31'd0, stall}, 32'd0);
    chk("reset result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++)
      run_md(vt[i].f, vt[i].a, vt[i].b, vt[i].eh, vt[i].el, vt[i].nm);

    for (int i = 0; i < 16; i++) begin
      case ($urandom_range(0, 3))
        0: fr = F_MULT;
        1: fr = F_MULTU;
        2: fr = F_DIV;
        default: fr = F_DIVU;
      endcase
      ra = $urandom;
      rb = (i % 4 == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      m  = model(fr, ra, rb);
      run_md(fr, ra, rb, m[63:32], m[31:0], "random");
    end

    // mflo held behind a running mult
    m = model(F_MULT, 32'd123, 32'hFFFF_FFD3);
    @(negedge clk);
    issue  = 1'b1;
    alu_op = 2'b10;
    funct  = F_MULT;
    rs_val = 32'd123;
    rt_val = 32'hFFFF_FFD3;
    @(posedge clk);
    #1;
    funct = F_MFLO;
    n     = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!stall) break;
      n++;
    end
    chk("mflo stall cycles", 32'(n), 32'd33);
    chk("mflo stall low", {31'd0, stall}, 32'd0);
    chk("mflo result", result, m[31:0]);
    chk("mflo hi", hi, m[63:32]);
    chk("mflo busy", {31'd0, busy}, 32'd0);
    prev_lo = m[31:0];
    @(posedge clk);
    #1;

    // moves while idle
    funct  = F_MTHI;
    rs_val = 32'h1234;
    #1;
    chk("mthi stall", {31'd0, stall}, 32'd0);
    @(posedge clk);
    #1;
    funct = F_MFLO;
    #1;
    chk("mthi hi", hi, 32'h1234);
    chk("mthi lo kept", lo, prev_lo);
    chk("mflo idle result", result, prev_lo);
    chk("mflo idle stall", {31'd0, stall}, 32'd0);
    funct  = F_MTLO;
    rs_val = 32'hABCD;
    @(posedge clk);
    #1;
    chk("mtlo lo", lo, 32'hABCD);
    chk("mtlo hi kept", hi, 32'h1234);
    funct = 6'b100000;
    #1;
    chk("add result", result, 32'd0);
    alu_op = 2'b00;
    funct  = F_MULT;
    @(posedge clk);
    #1;
    chk("aluop gate busy", {31'd0, busy}, 32'd0);

    // non-muldiv issue while busy never stalls; a move does
    alu_op = 2'b10;
    rs_val = 32'd3;
    rt_val = 32'd5;
    @(posedge clk);
    #1;
    funct = 6'b100000;
    #1;
    chk("add busy stall", {31'd0, stall}, 32'd0);
    funct  = F_MTHI;
    rs_val = 32'hFFFF;
    #1;
    chk("mthi busy stall", {31'd0, stall}, 32'd1);
    @(posedge clk);
    #1;
    chk("mthi busy hi kept", hi, 32'h1234);
    issue = 1'b0;
    funct = 6'd0;
    dcnt  = 0;
    for (int i = 0; i < 100 && dcnt == 0; i++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("mult 3*5 done seen", 32'(dcnt), 32'd1);
    chk("mult 3*5 lo", lo, 32'd15);
    chk("mult 3*5 hi", hi, 32'd0);

    // reset mid-CALC aborts without a HI/LO write
    @(negedge clk);
    issue  = 1'b1;
    funct  = F_MULT;
    rs_val = 32'd7;
    rt_val = 32'd9;
    @(posedge clk);
    #1;
    issue = 1'b0;
    funct = 6'd0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort hi", hi, 32'd0);
    chk("abort lo", lo, 32'd0);
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt  = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("abort no done", 32'(dcnt), 32'd0);
    chk("abort lo after", lo, 32'd0);
    chk("abort busy after", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
